// File: rtl/moving_sum_if.sv
// Sample/sum bus for the moving_sum boxcar accumulator.
// The master side (upstream producer) drives samples and the clear request.
// The slave side (the accumulator) returns the window sum, its strobe and
// the window-full flag.
interface moving_sum_if #(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 32
);
    logic                 clear;
    logic                 valid_in;
    logic [IN_WIDTH-1:0]  data_input;
    logic [OUT_WIDTH-1:0] data_output;
    logic                 valid_out;
    logic                 full;

    modport master (
        output clear,
        output valid_in,
        output data_input,
        input  data_output,
        input  valid_out,
        input  full
    );

    modport slave (
        input  clear,
        input  valid_in,
        input  data_input,
        output data_output,
        output valid_out,
        output full
    );
endinterface

// File: rtl/moving_sum.sv
// Sliding-window (boxcar) accumulator.
// Keeps a running signed sum of the last 2**LOG2_LEN accepted samples in a
// circular delay line. While the window is still filling no result is
// produced; once LEN samples have been accepted, every accepted sample
// produces one registered sum with a single-cycle strobe.
// The running sum is kept at OUT_WIDTH = IN_WIDTH + LOG2_LEN bits, which is
// wide enough for LEN full-scale samples, so no saturation is needed.
module moving_sum #(
    parameter int IN_WIDTH  = 24,
    parameter int LOG2_LEN  = 8,
    parameter int OUT_WIDTH = IN_WIDTH + LOG2_LEN
) (
    input  logic          clk,
    input  logic          reset_b,
    moving_sum_if.slave   bus
);

    localparam int LEN = 2 ** LOG2_LEN;
    localparam logic [LOG2_LEN-1:0] LAST_FILL = LOG2_LEN'(LEN - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Delay line: holds the last LEN accepted samples, oldest at wr_ptr.
    logic [IN_WIDTH-1:0] mem_q [LEN];
    logic                mem_we;
    logic [IN_WIDTH-1:0] mem_wdata;

    logic [0:0]           state_q,       state_d;
    logic [OUT_WIDTH-1:0] acc_q,         acc_d;
    logic [LOG2_LEN-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [LOG2_LEN-1:0]  fill_cnt_q,    fill_cnt_d;
    logic [OUT_WIDTH-1:0] data_output_q, data_output_d;
    logic                 valid_out_q,   valid_out_d;
    logic                 full_q,        full_d;

    logic signed [OUT_WIDTH-1:0] new_ext;
    logic signed [OUT_WIDTH-1:0] old_ext;

    // Sign-extend the incoming sample and the sample leaving the window.
    // The oldest slot is read here, before the same edge overwrites it.
    assign new_ext = OUT_WIDTH'($signed(bus.data_input));
    assign old_ext = OUT_WIDTH'($signed(mem_q[wr_ptr_q]));

    // Next-state logic: clear beats a sample, samples advance the window,
    // and a strobe is raised only for samples that leave the FSM in RUN.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        wr_ptr_d      = wr_ptr_q;
        fill_cnt_d    = fill_cnt_q;
        data_output_d = data_output_q;
        valid_out_d   = 1'b0;
        full_d        = full_q;
        mem_we        = 1'b0;
        mem_wdata     = bus.data_input;

        if (bus.clear) begin
            state_d       = ST_FILL;
            acc_d         = '0;
            wr_ptr_d      = '0;
            fill_cnt_d    = '0;
            data_output_d = '0;
            full_d        = 1'b0;
        end else if (bus.valid_in) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (state_q == ST_FILL) begin
                acc_d      = acc_q + new_ext;
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == LAST_FILL) begin
                    state_d       = ST_RUN;
                    full_d        = 1'b1;
                    data_output_d = acc_d;
                    valid_out_d   = 1'b1;
                end
            end else begin
                acc_d         = acc_q + new_ext - old_ext;
                data_output_d = acc_d;
                valid_out_d   = 1'b1;
            end
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= ST_FILL;
            acc_q         <= '0;
            wr_ptr_q      <= '0;
            fill_cnt_q    <= '0;
            data_output_q <= '0;
            valid_out_q   <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            wr_ptr_q      <= wr_ptr_d;
            fill_cnt_q    <= fill_cnt_d;
            data_output_q <= data_output_d;
            valid_out_q   <= valid_out_d;
            full_q        <= full_d;
        end
    end

    // Delay-line storage: no reset, slots are only read once written in RUN.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= mem_wdata;
        end
    end

    assign bus.data_output = data_output_q;
    assign bus.valid_out   = valid_out_q;
    assign bus.full        = full_q;

endmodule

// File: tb/tb_moving_sum.sv
// Self-checking bench for moving_sum (IN_WIDTH=8, LOG2_LEN=2, OUT_WIDTH=10).
// A queue-based reference model keeps the last LEN accepted samples and sums
// them directly; directed scenarios also compare against literal values.
module tb_moving_sum;

    localparam int IN_WIDTH  = 8;
    localparam int LOG2_LEN  = 2;
    localparam int OUT_WIDTH = 10;
    localparam int LEN       = 4;

    logic clk;
    logic reset_b;

    moving_sum_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    moving_sum #(
        .IN_WIDTH (IN_WIDTH),
        .LOG2_LEN (LOG2_LEN),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk    (clk),
        .reset_b(reset_b),
        .bus    (bus)
    );

    int checks;
    int passed;

    int window[$];
    int exp_data;
    bit exp_valid;
    bit exp_full;
    int strobes[$];

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: window sum is produced once LEN samples are held.
    task automatic model_clear();
        window.delete();
        exp_valid = 1'b0;
        exp_data  = 0;
        exp_full  = 1'b0;
    endtask

    task automatic model_step(input bit clr, input bit v, input int d);
        int s;
        if (clr) begin
            model_clear();
        end else if (v) begin
            window.push_back(d);
            if (window.size() > LEN) void'(window.pop_front());
            if (window.size() == LEN) begin
                s = 0;
                foreach (window[i]) s += window[i];
                exp_valid = 1'b1;
                exp_data  = s;
                exp_full  = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, clock it in, sample #1 after the edge.
    task automatic drive_cycle(input bit clr, input bit v, input int d);
        bus.clear      = clr;
        bus.valid_in   = v;
        bus.data_input = IN_WIDTH'(d);
        @(posedge clk);
        #1;
        model_step(clr, v, d);
        if (bus.valid_out === 1'b1) strobes.push_back(int'($signed(bus.data_output)));
        bus.clear    = 1'b0;
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_b        = 1'b0;
        bus.clear      = 1'b0;
        bus.valid_in   = 1'b0;
        bus.data_input = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.data_output !== '0) $display("[TB] FAIL reset_data got %0d want 0", bus.data_output); else passed++;
        checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL reset_valid got %0b want 0", bus.valid_out); else passed++;
        checks++; if (bus.full !== 1'b0) $display("[TB] FAIL reset_full got %0b want 0", bus.full); else passed++;
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic test_ramp(input string name);
        int vals[6] = '{1, 2, 3, 4, 5, 6};
        int want[3] = '{10, 14, 18};
        drive_cycle(1'b1, 1'b0, 0);
        strobes.delete();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b1, vals[i]);
            checks++; if (bus.valid_out !== exp_valid) $display("[TB] FAIL %s_valid[%0d] got %0b want %0b", name, i, bus.valid_out, exp_valid); else passed++;
            checks++; if (int'($signed(bus.data_output)) !== exp_data) $display("[TB] FAIL %s_data[%0d] got %0d want %0d", name, i, $signed(bus.data_output), exp_data); else passed++;
            checks++; if (bus.full !== exp_full) $display("[TB] FAIL %s_full[%0d] got %0b want %0b", name, i, bus.full, exp_full); else passed++;
        end
        checks++; if (strobes.size() != 3) $display("[TB] FAIL %s_count got %0d want 3", name, strobes.size()); else passed++;
        for (int i = 0; i < 3 && i < strobes.size(); i++) begin
            checks++; if (strobes[i] != want[i]) $display("[TB] FAIL %s_lit[%0d] got %0d want %0d", name, i, strobes[i], want[i]); else passed++;
        end
    endtask

    task automatic test_extremes();
        int want[5] = '{508, 253, -2, -257, -512};
        drive_cycle(1'b1, 1'b0, 0);
        strobes.delete();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 1'b1, (i < 4) ? 127 : -128);
            checks++; if (bus.valid_out !== exp_valid) $display("[TB] FAIL extreme_valid[%0d] got %0b want %0b", i, bus.valid_out, exp_valid); else passed++;
            checks++; if (int'($signed(bus.data_output)) !== exp_data) $display("[TB] FAIL extreme_data[%0d] got %0d want %0d", i, $signed(bus.data_output), exp_data); else passed++;
        end
        checks++; if (strobes.size() != 5) $display("[TB] FAIL extreme_count got %0d want 5", strobes.size()); else passed++;
        for (int i = 0; i < 5 && i < strobes.size(); i++) begin
            checks++; if (strobes[i] != want[i]) $display("[TB] FAIL extreme_lit[%0d] got %0d want %0d", i, strobes[i], want[i]); else passed++;
        end
    endtask

    task automatic test_impulse();
        int vals[9] = '{0, 0, 0, 0, 100, 0, 0, 0, 0};
        int want[6] = '{0, 100, 100, 100, 100, 0};
        drive_cycle(1'b1, 1'b0, 0);
        strobes.delete();
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1'b0, 1'b1, vals[i]);
            checks++; if (int'($signed(bus.data_output)) !== exp_data) $display("[TB] FAIL impulse_data[%0d] got %0d want %0d", i, $signed(bus.data_output), exp_data); else passed++;
        end
        checks++; if (strobes.size() != 6) $display("[TB] FAIL impulse_count got %0d want 6", strobes.size()); else passed++;
        for (int i = 0; i < 6 && i < strobes.size(); i++) begin
            checks++; if (strobes[i] != want[i]) $display("[TB] FAIL impulse_lit[%0d] got %0d want %0d", i, strobes[i], want[i]); else passed++;
        end
    endtask

    task automatic test_gaps();
        drive_cycle(1'b1, 1'b0, 0);
        strobes.delete();
        for (int i = 0; i < 13; i++) begin
            drive_cycle(1'b0, (i % 3) == 0, 5);
            checks++; if (bus.valid_out !== exp_valid) $display("[TB] FAIL gap_valid[%0d] got %0b want %0b", i, bus.valid_out, exp_valid); else passed++;
            checks++; if (int'($signed(bus.data_output)) !== exp_data) $display("[TB] FAIL gap_data[%0d] got %0d want %0d", i, $signed(bus.data_output), exp_data); else passed++;
        end
        checks++; if (strobes.size() != 2) $display("[TB] FAIL gap_count got %0d want 2", strobes.size()); else passed++;
        for (int i = 0; i < strobes.size(); i++) begin
            checks++; if (strobes[i] != 20) $display("[TB] FAIL gap_lit[%0d] got %0d want 20", i, strobes[i]); else passed++;
        end
    endtask

    task automatic test_clear();
        int d;
        drive_cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b1, 10 + i);
        drive_cycle(1'b1, 1'b1, 77);
        checks++; if (bus.full !== 1'b0) $display("[TB] FAIL clear_full got %0b want 0", bus.full); else passed++;
        checks++; if (bus.data_output !== '0) $display("[TB] FAIL clear_data got %0d want 0", $signed(bus.data_output)); else passed++;
        checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL clear_valid got %0b want 0", bus.valid_out); else passed++;
        strobes.delete();
        for (int i = 0; i < 4; i++) begin
            d = -3 + 7 * i;
            drive_cycle(1'b0, 1'b1, d);
            checks++; if (bus.valid_out !== exp_valid) $display("[TB] FAIL clear_refill_valid[%0d] got %0b want %0b", i, bus.valid_out, exp_valid); else passed++;
        end
        checks++; if (strobes.size() != 1 || strobes[0] != 30) $display("[TB] FAIL clear_refill_sum got %0d strobes want one of 30", strobes.size()); else passed++;
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b1, 20 + i);
        #2;
        reset_b = 1'b0;
        #1;
        model_clear();
        checks++; if (bus.data_output !== '0) $display("[TB] FAIL areset_data got %0d want 0", $signed(bus.data_output)); else passed++;
        checks++; if (bus.full !== 1'b0) $display("[TB] FAIL areset_full got %0b want 0", bus.full); else passed++;
        @(negedge clk);
        reset_b = 1'b1;
        test_ramp("post_reset");
    endtask

    task automatic test_back_to_back_random();
        bit clr;
        bit v;
        int d;
        drive_cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < 300; i++) begin
            clr = ($urandom_range(0, 39) == 0);
            v   = ($urandom_range(0, 9) < 8);
            d   = int'($urandom_range(0, 255)) - 128;
            drive_cycle(clr, v, d);
            checks++; if (bus.valid_out !== exp_valid) $display("[TB] FAIL rand_valid[%0d] got %0b want %0b", i, bus.valid_out, exp_valid); else passed++;
            checks++; if (int'($signed(bus.data_output)) !== exp_data) $display("[TB] FAIL rand_data[%0d] got %0d want %0d", i, $signed(bus.data_output), exp_data); else passed++;
            checks++; if (bus.full !== exp_full) $display("[TB] FAIL rand_full[%0d] got %0b want %0b", i, bus.full, exp_full); else passed++;
        end
    endtask

    // Scenario sequence.
    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_ramp("ramp");
        test_extremes();
        test_impulse();
        test_gaps();
        test_clear();
        test_async_reset();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
